strip_output_stage: RTL and testbench
=====================================

// Module: strip_output_stage
// PURPOSE
//  Output stage directly downstream of the biquad filter chain in the channel strip.
//  - Takes the wide signed filter result and applies a Q2.14 channel gain.
//  - Ramps that gain click-free on changes and on mute.
//  - Rounds and saturates to 16-bit PCM for the codec serializer.
//  - Keeps clip and peak statistics for the front-panel meter.
// PARAMETERS
//  IN_W       48     width of signed input sample from filter chain
//  SHIFT      14     fractional bits of gain (Q2.14; 16384 = unity)
//  RAMP_STEP  64     max change of effective gain per accepted sample
//  PEAK_HOLD  48000  accepted samples a peak value is held before refresh
// PORTS
//  clk          in   1      clock
//  reset_n      in   1      asynchronous, active-low reset
//  in_valid     in   1      in_data valid
//  in_ready     out  1      stage can accept a sample
//  in_data      in   IN_W   signed filter output sample
//  gain         in   16     unsigned Q2.14 target gain (0..65535 = 0..~4.0)
//  mute         in   1      1: target gain forced to 0 (ramped)
//  out_valid    out  1      out_data valid
//  out_ready    in   1      downstream accepts out_data
//  out_data     out  16     signed saturated PCM sample
//  clip         out  1      last delivered sample was saturated
//  clip_count   out  16     saturating count of clipped samples
//  peak         out  15     held max |out_data| (0..32767)
//  clear_stats  in   1      sync pulse: clear clip_count, peak, hold counter
// BEHAVIOUR
//  Reset values:
//  - All outputs 0 except in_ready=1.
//  - g_eff (effective gain) = 0, so the stage fades in after reset.
//  FSM: IDLE -> MUL -> SAT -> HOLD -> IDLE.
//  - IDLE: in_ready=1. On in_valid&in_ready, latch in_data and g_eff; go MUL.
//  - MUL: prod = in_data * $signed({1'b0,g_eff}), full width IN_W+17; go SAT.
//  - SAT: r = (prod + 2**(SHIFT-1)) >>> SHIFT (round half toward +inf).
//    - Clamp r to [-32768, 32767]; clip_next = (clamp applied).
//    - Register out_data, clip, and stats; go HOLD.
//  - HOLD: out_valid=1; out_data and clip stable until out_ready. On out_valid&out_ready go IDLE.
//  - out_valid is low in all states other than HOLD.
//  Latency and throughput:
//  - Accept in cycle N -> out_valid=1 in cycle N+3.
//  - Minimum 4 cycles per sample when out_ready=1.
//  - in_ready=0 in MUL, SAT and HOLD; no input buffering.
//  Gain ramp:
//  - target = mute ? 0 : gain.
//  - At each input accept, after latching the old g_eff: g_eff moves toward target by min(RAMP_STEP, |target-g_eff|).
//  - gain and mute are sampled only at accept; changes mid-sample do not affect the in-flight sample.
//  Stats (updated in SAT):
//  - clip_count += clip_next, saturating at 16'hFFFF.
//  - a = |out| with |-32768| mapped to 32767.
//  - If a > peak: peak = a and the hold counter is reset to 0.
//  - Otherwise the hold counter increments. When it reaches PEAK_HOLD: peak = a, counter reset.
//  - clear_stats takes priority over an update in the same cycle; that cycle's event is discarded. It does not affect out_data, clip or the FSM.
//  Reset mid-operation: the in-flight sample is discarded; all state returns to reset values immediately.
// TESTING
//  - After reset, mute=0, gain=16384, constant in_data=16384:
//    -> out_data sequence 0, 64, 128, ..., then 16384 from the 257th sample onward; clip=0.
//  - g_eff=16384 settled: in_data=1000 -> 1000. in_data=40000 -> 32767, clip=1. in_data=-40000 -> -32768, clip=1.
//    -> clip_count=2, peak=32767.
//  - gain=8192 settled: in_data=3 -> 2 and in_data=-3 -> -1 (rounding). gain=32768, in_data=20000 -> 32767, clip=1.
//  - Handshake: hold out_ready=0 for 10 cycles.
//    -> out_valid stays 1 and out_data is stable; in_ready=0 throughout.
//    -> Accept-to-valid latency is exactly 3 cycles.
//  - Assert mute from unity gain: 256 samples ramp to 0, then out_data=0. clear_stats in a clip cycle -> clip_count=0.
//  - Assert reset_n=0 during SAT -> outputs 0, in_ready=1 next cycle, g_eff=0; no stale out_valid after release.

Source files
------------

// File: rtl/strip_output_stage.sv
// Channel-strip output stage: applies a ramped Q2.14 gain to the wide filter
// result, rounds and saturates to 16-bit PCM, and keeps clip/peak statistics
// for the front-panel meter. One sample in flight at a time (4-state FSM).
module strip_output_stage #(
    parameter int IN_W      = 48,
    parameter int SHIFT     = 14,
    parameter int RAMP_STEP = 64,
    parameter int PEAK_HOLD = 48000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [IN_W-1:0] in_data,
    input  logic [15:0]            gain,
    input  logic                   mute,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [15:0]     out_data,
    output logic                   clip,
    output logic [15:0]            clip_count,
    output logic [14:0]            peak,
    input  logic                   clear_stats
);

    localparam int PROD_W = IN_W + 17;
    localparam int HOLD_W = $clog2(PEAK_HOLD + 1);

    localparam logic [15:0]              STEP      = 16'(RAMP_STEP);
    localparam logic signed [PROD_W-1:0] ROUND_ADD = PROD_W'(1) <<< (SHIFT - 1);
    localparam logic signed [PROD_W-1:0] PCM_MAX   = PROD_W'(32767);
    localparam logic signed [PROD_W-1:0] PCM_MIN   = PROD_W'(-32768);
    localparam logic [HOLD_W-1:0]        HOLD_LAST = HOLD_W'(PEAK_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        SAT  = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t                   state_reg;
    logic                     in_ready_reg;
    logic                     out_valid_reg;
    logic signed [IN_W-1:0]   data_reg;
    logic [15:0]              g_lat_reg;
    logic [15:0]              g_eff_reg;
    logic signed [PROD_W-1:0] prod_reg;
    logic signed [15:0]       out_data_reg;
    logic                     clip_reg;
    logic [15:0]              clip_count_reg;
    logic [14:0]              peak_reg;
    logic [HOLD_W-1:0]        hold_cnt_reg;

    logic [15:0]              target;
    logic [15:0]              g_ramp;
    logic signed [PROD_W-1:0] mul_a;
    logic signed [PROD_W-1:0] mul_b;
    logic signed [PROD_W-1:0] rounded;
    logic signed [PROD_W-1:0] shifted;
    logic signed [15:0]       sat_val;
    logic [15:0]              sat_neg;
    logic                     clip_next;
    logic [14:0]              abs_val;

    assign target = mute ? 16'd0 : gain;

    // Next effective gain: step toward target by at most STEP per accepted sample.
    always_comb begin
        g_ramp = g_eff_reg;
        if (target > g_eff_reg) begin
            if ((target - g_eff_reg) > STEP) g_ramp = g_eff_reg + STEP;
            else                             g_ramp = target;
        end else if (target < g_eff_reg) begin
            if ((g_eff_reg - target) > STEP) g_ramp = g_eff_reg - STEP;
            else                             g_ramp = target;
        end
    end

    // Both operands sign-extended to the full product width; the true product always fits.
    assign mul_a = PROD_W'(data_reg);
    assign mul_b = PROD_W'($signed({1'b0, g_lat_reg}));

    // Round half toward +inf, drop fraction bits, clamp to 16-bit PCM, derive |out| for the meter.
    always_comb begin
        rounded   = prod_reg + ROUND_ADD;
        shifted   = rounded >>> SHIFT;
        sat_val   = shifted[15:0];
        clip_next = 1'b0;
        if (shifted > PCM_MAX) begin
            sat_val   = 16'sh7FFF;
            clip_next = 1'b1;
        end else if (shifted < PCM_MIN) begin
            sat_val   = -16'sh8000;
            clip_next = 1'b1;
        end
        sat_neg = -sat_val;
        if (!sat_val[15])               abs_val = sat_val[14:0];
        else if (sat_val == -16'sh8000) abs_val = 15'h7FFF;
        else                            abs_val = sat_neg[14:0];
    end

    // Sample FSM: accept, multiply, round/saturate, hold until downstream takes it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            data_reg      <= '0;
            g_lat_reg     <= '0;
            g_eff_reg     <= '0;
            prod_reg      <= '0;
            out_data_reg  <= '0;
            clip_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        data_reg     <= in_data;
                        g_lat_reg    <= g_eff_reg;
                        g_eff_reg    <= g_ramp;
                        in_ready_reg <= 1'b0;
                        state_reg    <= MUL;
                    end
                end
                MUL: begin
                    prod_reg  <= mul_a * mul_b;
                    state_reg <= SAT;
                end
                SAT: begin
                    out_data_reg  <= sat_val;
                    clip_reg      <= clip_next;
                    out_valid_reg <= 1'b1;
                    state_reg     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Meter statistics; a clear wins over the update of the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clip_count_reg <= '0;
            peak_reg       <= '0;
            hold_cnt_reg   <= '0;
        end else if (clear_stats) begin
            clip_count_reg <= '0;
            peak_reg       <= '0;
            hold_cnt_reg   <= '0;
        end else if (state_reg == SAT) begin
            if (clip_next && (clip_count_reg != 16'hFFFF))
                clip_count_reg <= clip_count_reg + 16'd1;
            if (abs_val > peak_reg) begin
                peak_reg     <= abs_val;
                hold_cnt_reg <= '0;
            end else if (hold_cnt_reg == HOLD_LAST) begin
                peak_reg     <= abs_val;
                hold_cnt_reg <= '0;
            end else begin
                hold_cnt_reg <= hold_cnt_reg + HOLD_W'(1);
            end
        end
    end

    assign in_ready   = in_ready_reg;
    assign out_valid  = out_valid_reg;
    assign out_data   = out_data_reg;
    assign clip       = clip_reg;
    assign clip_count = clip_count_reg;
    assign peak       = peak_reg;

endmodule

// File: tb/tb_strip_output_stage.sv
// Directed bench for strip_output_stage: fade-in, rounding, saturation,
// handshake stall, mute ramp, stats clear and asynchronous reset mid-sample.
module tb_strip_output_stage;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [47:0] in_data = '0;
    logic [15:0]        gain = 16'd16384;
    logic               mute = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic signed [15:0] out_data;
    logic               clip;
    logic [15:0]        clip_count;
    logic [14:0]        peak;
    logic               clear_stats = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    strip_output_stage dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .gain        (gain),
        .mute        (mute),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .clip        (clip),
        .clip_count  (clip_count),
        .peak        (peak),
        .clear_stats (clear_stats)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint observed, input longint expected);
        n_checks++;
        if (observed == expected) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, observed, expected);
    endtask

    // One sample through the stage; optionally pulses clear_stats while the sample is in SAT.
    task automatic xfer(input logic signed [47:0] d, input bit clr,
                        output int res, output int clp);
        int lat;
        int wait_cnt;
        wait_cnt = 0;
        while (!in_ready && wait_cnt < 50) begin
            @(negedge clk);
            wait_cnt++;
        end
        if (!in_ready) check("in_ready_timeout", 0, 1);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
            clear_stats = clr && (lat == 2);
        end
        clear_stats = 1'b0;
        check("latency", lat, 3);
        res = int'(out_data);
        clp = int'(clip);
        $display("xfer in=%0d out=%0d clip=%0d lat=%0d", d, res, clp, lat);
        if (out_ready) @(negedge clk);
    endtask

    // Send n zero samples to let the gain ramp settle.
    task automatic settle(input int n);
        int r, c;
        for (int i = 0; i < n; i++) xfer(48'sd0, 1'b0, r, c);
    endtask

    initial begin
        int r, c, exp_v;

        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_clip", clip, 0);
        check("rst_clip_count", clip_count, 0);
        check("rst_peak", peak, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Fade-in from g_eff=0 at unity target.
        for (int k = 0; k < 300; k++) begin
            xfer(48'sd16384, 1'b0, r, c);
            exp_v = (k < 256) ? 64 * k : 16384;
            check("fade_in", r, exp_v);
            if (k == 299) check("fade_in_clip", c, 0);
        end

        // Unity gain: pass-through and saturation.
        xfer(48'sd1000, 1'b0, r, c);
        check("unity_1000", r, 1000);
        check("unity_1000_clip", c, 0);
        xfer(48'sd40000, 1'b0, r, c);
        check("sat_pos", r, 32767);
        check("sat_pos_clip", c, 1);
        xfer(-48'sd40000, 1'b0, r, c);
        check("sat_neg", r, -32768);
        check("sat_neg_clip", c, 1);
        check("clip_count_2", clip_count, 2);
        check("peak_max", peak, 32767);

        // Half gain: rounding half toward +inf.
        gain = 16'd8192;
        settle(128);
        xfer(48'sd3, 1'b0, r, c);
        check("round_pos", r, 2);
        xfer(-48'sd3, 1'b0, r, c);
        check("round_neg", r, -1);

        // Double gain saturates.
        gain = 16'd32768;
        settle(384);
        xfer(48'sd20000, 1'b0, r, c);
        check("gain2_sat", r, 32767);
        check("gain2_clip", c, 1);
        check("clip_count_3", clip_count, 3);

        // Backpressure: output held for 10 cycles.
        out_ready = 1'b0;
        xfer(48'sd100, 1'b0, r, c);
        check("stall_data", r, 200);
        for (int i = 0; i < 10; i++) begin
            check("stall_valid", out_valid, 1);
            check("stall_stable", out_data, 200);
            check("stall_in_ready", in_ready, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("release_valid", out_valid, 0);
        check("release_in_ready", in_ready, 1);

        // Mute ramp from unity down to 0.
        gain = 16'd16384;
        settle(256);
        mute = 1'b1;
        for (int k = 0; k < 260; k++) begin
            xfer(48'sd16384, 1'b0, r, c);
            exp_v = (k < 256) ? 16384 - 64 * k : 0;
            check("mute_ramp", r, exp_v);
        end

        // clear_stats during the SAT cycle of a clipping sample.
        mute = 1'b0;
        settle(256);
        xfer(48'sd40000, 1'b1, r, c);
        check("clr_out", r, 32767);
        check("clr_clip", c, 1);
        check("clr_clip_count", clip_count, 0);
        check("clr_peak", peak, 0);

        // Asynchronous reset while the sample sits in SAT.
        in_valid = 1'b1;
        in_data  = 48'sd40000;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("arst_in_ready", in_ready, 1);
        check("arst_out_valid", out_valid, 0);
        check("arst_out_data", out_data, 0);
        check("arst_clip", clip, 0);
        @(negedge clk);
        check("arst_in_ready_next", in_ready, 1);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("no_stale_valid", out_valid, 0);
        end
        xfer(48'sd16384, 1'b0, r, c);
        check("post_rst_geff0", r, 0);
        xfer(48'sd16384, 1'b0, r, c);
        check("post_rst_ramp", r, 64);
        check("post_rst_clip_count", clip_count, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
